// File: rtl/read_control_pkg.sv
// read_control_pkg
//   Shared constants, types and helpers for the image-pool read path.
//   Client ids, pool geometry, derived bus widths, the return-tag
//   layout and two small combinational helpers.
package read_control_pkg;

  // Pool geometry
  localparam int IMG_GRP_NUM     = 3;
  localparam int ROW_PARA        = 4;
  localparam int CHL_PARA        = 8;
  localparam int BANK_ADDR_WIDTH = 12;
  localparam int BANK_UNIT_WIDTH = 8;
  localparam int RAM_LATENCY     = 2;

  // Read clients
  localparam int RD_CLI_CONV = 0;
  localparam int RD_CLI_MISC = 1;
  localparam int RD_CLI_SAVE = 2;
  localparam int RD_CLI_NUM  = 3;
  localparam int RD_CLI_ID_W = 2;

  // Derived widths
  localparam int IMG_BANK_WIDTH = BANK_UNIT_WIDTH * CHL_PARA;
  localparam int IMG_DATA_WIDTH = ROW_PARA * IMG_BANK_WIDTH;
  localparam int IMG_ADDR_WIDTH = ROW_PARA * BANK_ADDR_WIDTH;

  // One tag stage per cycle between the issue register and the cycle
  // in which the pool data for that issue is present on read_data_i.
  localparam int TAG_DEPTH = RAM_LATENCY + 1;

  typedef logic [RD_CLI_ID_W-1:0] cli_id_t;
  typedef logic [IMG_GRP_NUM-1:0] grp_sel_t;

  typedef struct packed {
    logic                valid;
    cli_id_t             cli;
    logic [ROW_PARA-1:0] bank_en;
  } rd_tag_t;

  // Round-robin successor: conv -> misc -> save -> conv
  function automatic cli_id_t next_cli(input cli_id_t id);
    return (id == cli_id_t'(RD_CLI_NUM - 1)) ? '0 : id + cli_id_t'(1);
  endfunction

  // Exactly one group bit set; zero or several bits means no request
  function automatic logic is_onehot(input grp_sel_t v);
    return (v != '0) && ((v & (v - grp_sel_t'(1))) == '0);
  endfunction

endpackage

// File: rtl/read_control_arbiter.sv
// read_arbiter
//   Per-group read engine: round-robin grant over the three clients,
//   issue registers towards the pool and the return-tag shift register.
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   i_req          per-client request targeting this group (already one-hot filtered)
//   i_bank_en      per-client bank enables
//   i_addr         per-client per-bank addresses
//   i_read_data    this group's pool data
//   o_grant        per-client grant this cycle (combinational)
//   o_bank_en      registered bank enables to the pool
//   o_addr         registered addresses to the pool (hold when idle)
//   o_ret_valid    per-client return strobe, aligned with i_read_data
//   o_ret_data     i_read_data with disabled banks zeroed
module read_arbiter
  import read_control_pkg::*;
(
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [RD_CLI_NUM-1:0]                    i_req,
  input  logic [RD_CLI_NUM-1:0][ROW_PARA-1:0]      i_bank_en,
  input  logic [RD_CLI_NUM-1:0][IMG_ADDR_WIDTH-1:0] i_addr,
  input  logic [IMG_DATA_WIDTH-1:0]                i_read_data,
  output logic [RD_CLI_NUM-1:0]                    o_grant,
  output logic [ROW_PARA-1:0]                      o_bank_en,
  output logic [IMG_ADDR_WIDTH-1:0]                o_addr,
  output logic [RD_CLI_NUM-1:0]                    o_ret_valid,
  output logic [IMG_DATA_WIDTH-1:0]                o_ret_data
);

  cli_id_t                   r_ptr;
  logic [ROW_PARA-1:0]       r_bank_en;
  logic [IMG_ADDR_WIDTH-1:0] r_addr;
  rd_tag_t                   r_tag [TAG_DEPTH];

  logic [RD_CLI_NUM-1:0]     w_grant;
  cli_id_t                   w_win;
  cli_id_t                   w_idx;
  logic                      w_found;
  rd_tag_t                   w_ret_tag;

  // Search starts at the pointer; first requester found wins.
  always_comb begin
    w_grant = '0;
    w_win   = r_ptr;
    w_found = 1'b0;
    w_idx   = r_ptr;
    for (int k = 0; k < RD_CLI_NUM; k++) begin
      if (!w_found && i_req[w_idx]) begin
        w_grant[w_idx] = 1'b1;
        w_win          = w_idx;
        w_found        = 1'b1;
      end
      w_idx = next_cli(w_idx);
    end
  end

  assign o_grant   = w_grant;
  assign o_bank_en = r_bank_en;
  assign o_addr    = r_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr     <= cli_id_t'(RD_CLI_CONV);
      r_bank_en <= '0;
      r_addr    <= '0;
      for (int i = 0; i < TAG_DEPTH; i++) r_tag[i] <= '0;
    end else begin
      if (w_found) begin
        r_ptr     <= next_cli(w_win);
        r_bank_en <= i_bank_en[w_win];
        r_addr    <= i_addr[w_win];
      end else begin
        // Idle: no banks enabled, address left where it was
        r_bank_en <= '0;
      end
      r_tag[0].valid   <= w_found;
      r_tag[0].cli     <= w_win;
      r_tag[0].bank_en <= w_found ? i_bank_en[w_win] : '0;
      for (int i = 1; i < TAG_DEPTH; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // Last tag stage lines up with the pool data of the same read
  always_comb begin
    w_ret_tag   = r_tag[TAG_DEPTH-1];
    o_ret_valid = '0;
    o_ret_data  = '0;
    for (int c = 0; c < RD_CLI_NUM; c++)
      o_ret_valid[c] = w_ret_tag.valid && (w_ret_tag.cli == cli_id_t'(c));
    for (int b = 0; b < ROW_PARA; b++)
      if (w_ret_tag.bank_en[b])
        o_ret_data[b*IMG_BANK_WIDTH +: IMG_BANK_WIDTH] = i_read_data[b*IMG_BANK_WIDTH +: IMG_BANK_WIDTH];
  end

endmodule

// File: rtl/read_control.sv
// read_control
//   Read-side front end of the image memory pool. Arbitrates conv, misc
//   and save read requests per image group, drives bank enables and
//   addresses to the pool and routes returned data to the requester
//   RAM_LATENCY+2 cycles after acceptance.
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   {c}_read_group_id_i        one-hot target group, zero = idle
//   {c}_read_bank_en_i         banks to read
//   {c}_read_addr_i            per-bank addresses
//   {c}_read_ready_o           request accepted this cycle
//   {c}_read_valid_o           one-cycle return strobe
//   {c}_read_data_o            returned data, disabled banks zero
//   read_bank_en_o/read_addr_o to the pool, group g at slice g
//   read_data_i                from the pool, group g at slice g
//
// Handshake: a request is a one-hot group_id held stable together with
// bank_en/addr until ready_o is high; the cycle where both are high is
// the accept. ready_o is combinational from the requests and never
// depends on valid_o. Returns carry no back-pressure: valid_o is a
// single-cycle strobe the client must consume.
module read_control
  import read_control_pkg::*;
(
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [IMG_GRP_NUM-1:0]                conv_read_group_id_i,
  input  logic [ROW_PARA-1:0]                   conv_read_bank_en_i,
  input  logic [IMG_ADDR_WIDTH-1:0]             conv_read_addr_i,
  output logic                                  conv_read_ready_o,
  output logic                                  conv_read_valid_o,
  output logic [IMG_DATA_WIDTH-1:0]             conv_read_data_o,
  input  logic [IMG_GRP_NUM-1:0]                misc_read_group_id_i,
  input  logic [ROW_PARA-1:0]                   misc_read_bank_en_i,
  input  logic [IMG_ADDR_WIDTH-1:0]             misc_read_addr_i,
  output logic                                  misc_read_ready_o,
  output logic                                  misc_read_valid_o,
  output logic [IMG_DATA_WIDTH-1:0]             misc_read_data_o,
  input  logic [IMG_GRP_NUM-1:0]                save_read_group_id_i,
  input  logic [ROW_PARA-1:0]                   save_read_bank_en_i,
  input  logic [IMG_ADDR_WIDTH-1:0]             save_read_addr_i,
  output logic                                  save_read_ready_o,
  output logic                                  save_read_valid_o,
  output logic [IMG_DATA_WIDTH-1:0]             save_read_data_o,
  output logic [IMG_GRP_NUM*ROW_PARA-1:0]       read_bank_en_o,
  output logic [IMG_GRP_NUM*IMG_ADDR_WIDTH-1:0] read_addr_o,
  input  logic [IMG_GRP_NUM*IMG_DATA_WIDTH-1:0] read_data_i
);

  logic [RD_CLI_NUM-1:0][IMG_GRP_NUM-1:0]    w_gid;
  logic [RD_CLI_NUM-1:0][ROW_PARA-1:0]       w_bank_en;
  logic [RD_CLI_NUM-1:0][IMG_ADDR_WIDTH-1:0] w_addr;
  logic [IMG_GRP_NUM-1:0][RD_CLI_NUM-1:0]    w_grp_req;
  logic [IMG_GRP_NUM-1:0][RD_CLI_NUM-1:0]    w_grant;
  logic [IMG_GRP_NUM-1:0][RD_CLI_NUM-1:0]    w_ret_valid;
  logic [IMG_GRP_NUM-1:0][IMG_DATA_WIDTH-1:0] w_ret_data;
  logic [RD_CLI_NUM-1:0]                     w_ready;
  logic [RD_CLI_NUM-1:0]                     w_valid_nxt;
  logic [RD_CLI_NUM-1:0][IMG_DATA_WIDTH-1:0] w_data_nxt;

  logic [RD_CLI_NUM-1:0]                     r_valid;
  logic [RD_CLI_NUM-1:0][IMG_DATA_WIDTH-1:0] r_data;

  assign w_gid[RD_CLI_CONV]     = conv_read_group_id_i;
  assign w_gid[RD_CLI_MISC]     = misc_read_group_id_i;
  assign w_gid[RD_CLI_SAVE]     = save_read_group_id_i;
  assign w_bank_en[RD_CLI_CONV] = conv_read_bank_en_i;
  assign w_bank_en[RD_CLI_MISC] = misc_read_bank_en_i;
  assign w_bank_en[RD_CLI_SAVE] = save_read_bank_en_i;
  assign w_addr[RD_CLI_CONV]    = conv_read_addr_i;
  assign w_addr[RD_CLI_MISC]    = misc_read_addr_i;
  assign w_addr[RD_CLI_SAVE]    = save_read_addr_i;

  // Multi-hot group ids are dropped here so no group ever sees them
  always_comb begin
    w_grp_req = '0;
    for (int c = 0; c < RD_CLI_NUM; c++)
      for (int g = 0; g < IMG_GRP_NUM; g++)
        w_grp_req[g][c] = w_gid[c][g] & is_onehot(w_gid[c]);
  end

  for (genvar g = 0; g < IMG_GRP_NUM; g++) begin : g_grp
    read_arbiter u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_req       (w_grp_req[g]),
      .i_bank_en   (w_bank_en),
      .i_addr      (w_addr),
      .i_read_data (read_data_i[g*IMG_DATA_WIDTH +: IMG_DATA_WIDTH]),
      .o_grant     (w_grant[g]),
      .o_bank_en   (read_bank_en_o[g*ROW_PARA +: ROW_PARA]),
      .o_addr      (read_addr_o[g*IMG_ADDR_WIDTH +: IMG_ADDR_WIDTH]),
      .o_ret_valid (w_ret_valid[g]),
      .o_ret_data  (w_ret_data[g])
    );
  end

  // A client is accepted by at most one group per cycle, so its return
  // strobes are one-hot across groups and a plain OR merges them.
  always_comb begin
    w_ready     = '0;
    w_valid_nxt = '0;
    w_data_nxt  = '0;
    for (int g = 0; g < IMG_GRP_NUM; g++)
      for (int c = 0; c < RD_CLI_NUM; c++) begin
        w_ready[c] = w_ready[c] | w_grant[g][c];
        if (w_ret_valid[g][c]) begin
          w_valid_nxt[c] = 1'b1;
          w_data_nxt[c]  = w_data_nxt[c] | w_ret_data[g];
        end
      end
    // Nothing is accepted while reset is asserted
    w_ready = w_ready & {RD_CLI_NUM{rst_n}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      r_valid <= w_valid_nxt;
      for (int c = 0; c < RD_CLI_NUM; c++)
        if (w_valid_nxt[c]) r_data[c] <= w_data_nxt[c];
    end
  end

  assign conv_read_ready_o = w_ready[RD_CLI_CONV];
  assign misc_read_ready_o = w_ready[RD_CLI_MISC];
  assign save_read_ready_o = w_ready[RD_CLI_SAVE];
  assign conv_read_valid_o = r_valid[RD_CLI_CONV];
  assign misc_read_valid_o = r_valid[RD_CLI_MISC];
  assign save_read_valid_o = r_valid[RD_CLI_SAVE];
  assign conv_read_data_o  = r_data[RD_CLI_CONV];
  assign misc_read_data_o  = r_data[RD_CLI_MISC];
  assign save_read_data_o  = r_data[RD_CLI_SAVE];

endmodule

// File: tb/tb_read_control.sv
// tb_read_control
//   Directed bench for read_control with a latency-accurate pool model,
//   per-cycle checks of ready/bank_en/addr and a per-client scoreboard
//   checked by an independent return monitor.
module tb_read_control;
  import read_control_pkg::*;

  localparam int D   = IMG_DATA_WIDTH;
  localparam int A   = IMG_ADDR_WIDTH;
  localparam int BW  = IMG_BANK_WIDTH;
  localparam int AW  = BANK_ADDR_WIDTH;
  localparam int LAT = RAM_LATENCY + 2;
  localparam int W   = D + 32;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT wiring ----------------
  logic [2:0]   gid  [3];
  logic [3:0]   ben  [3];
  logic [A-1:0] addr [3];

  logic [2:0]   conv_read_group_id_i, misc_read_group_id_i, save_read_group_id_i;
  logic [3:0]   conv_read_bank_en_i, misc_read_bank_en_i, save_read_bank_en_i;
  logic [A-1:0] conv_read_addr_i, misc_read_addr_i, save_read_addr_i;
  logic         conv_read_ready_o, misc_read_ready_o, save_read_ready_o;
  logic         conv_read_valid_o, misc_read_valid_o, save_read_valid_o;
  logic [D-1:0] conv_read_data_o, misc_read_data_o, save_read_data_o;
  logic [IMG_GRP_NUM*ROW_PARA-1:0] read_bank_en_o;
  logic [IMG_GRP_NUM*A-1:0]        read_addr_o;
  logic [IMG_GRP_NUM*D-1:0]        read_data_i = '0;
  logic [IMG_GRP_NUM*D-1:0]        pool_s1     = '0;

  assign conv_read_group_id_i = gid[0];
  assign misc_read_group_id_i = gid[1];
  assign save_read_group_id_i = gid[2];
  assign conv_read_bank_en_i  = ben[0];
  assign misc_read_bank_en_i  = ben[1];
  assign save_read_bank_en_i  = ben[2];
  assign conv_read_addr_i     = addr[0];
  assign misc_read_addr_i     = addr[1];
  assign save_read_addr_i     = addr[2];

  logic [2:0]   rdy, vld;
  logic [D-1:0] dat [3];
  assign rdy    = {save_read_ready_o, misc_read_ready_o, conv_read_ready_o};
  assign vld    = {save_read_valid_o, misc_read_valid_o, conv_read_valid_o};
  assign dat[0] = conv_read_data_o;
  assign dat[1] = misc_read_data_o;
  assign dat[2] = save_read_data_o;

  read_control dut (
    .clk(clk), .rst_n(rst_n),
    .conv_read_group_id_i(conv_read_group_id_i), .conv_read_bank_en_i(conv_read_bank_en_i),
    .conv_read_addr_i(conv_read_addr_i), .conv_read_ready_o(conv_read_ready_o),
    .conv_read_valid_o(conv_read_valid_o), .conv_read_data_o(conv_read_data_o),
    .misc_read_group_id_i(misc_read_group_id_i), .misc_read_bank_en_i(misc_read_bank_en_i),
    .misc_read_addr_i(misc_read_addr_i), .misc_read_ready_o(misc_read_ready_o),
    .misc_read_valid_o(misc_read_valid_o), .misc_read_data_o(misc_read_data_o),
    .save_read_group_id_i(save_read_group_id_i), .save_read_bank_en_i(save_read_bank_en_i),
    .save_read_addr_i(save_read_addr_i), .save_read_ready_o(save_read_ready_o),
    .save_read_valid_o(save_read_valid_o), .save_read_data_o(save_read_data_o),
    .read_bank_en_o(read_bank_en_o), .read_addr_o(read_addr_o), .read_data_i(read_data_i)
  );

  // ---------------- pool model: data valid RAM_LATENCY cycles after issue ----------------
  function automatic logic [BW-1:0] pool_word(input int g, input int b, input logic [AW-1:0] a);
    return {4'(g), 4'(b), a, ~a, 32'hC0DE_0000 | 32'(g * 16 + b)};
  endfunction

  always @(posedge clk) begin
    for (int g = 0; g < IMG_GRP_NUM; g++)
      for (int b = 0; b < ROW_PARA; b++)
        pool_s1[g*D + b*BW +: BW] <= pool_word(g, b, read_addr_o[g*A + b*AW +: AW]);
    read_data_i <= pool_s1;
  end

  function automatic logic [D-1:0] exp_data(input int g, input logic [3:0] en, input logic [A-1:0] a);
    logic [D-1:0] r;
    r = '0;
    for (int b = 0; b < ROW_PARA; b++)
      if (en[b]) r[b*BW +: BW] = pool_word(g, b, a[b*AW +: AW]);
    return r;
  endfunction

  function automatic int grp_of(input logic [2:0] id);
    for (int g = 0; g < IMG_GRP_NUM; g++) if (id[g]) return g;
    return 0;
  endfunction

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];
  logic [W-1:0] exp_q2[$];

  task automatic chk(input string name, input logic [D-1:0] act, input logic [D-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [W-1:0] e);
    case (c)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  // Expected pool-side outputs (set by the bench's own grant expectations)
  logic [11:0]  m_ben;
  logic [A-1:0] m_addr [3];

  // One cycle: check ready/bank_en/addr, record expected returns, retire accepted requests
  task automatic step(input logic [2:0] exp_rdy, input string name);
    logic [11:0] nxt_ben;
    int g;
    @(negedge clk);
    chk({name, "_ready"},   D'(rdy), D'(exp_rdy));
    chk({name, "_bank_en"}, D'(read_bank_en_o), D'(m_ben));
    chk({name, "_addr"},    D'(read_addr_o), D'({m_addr[2], m_addr[1], m_addr[0]}));
    nxt_ben = '0;
    for (int c = 0; c < 3; c++)
      if (exp_rdy[c]) begin
        g = grp_of(gid[c]);
        nxt_ben[g*4 +: 4] = ben[c];
        m_addr[g] = addr[c];
        push(c, {cyc + LAT, exp_data(g, ben[c], addr[c])});
      end
    m_ben = nxt_ben;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) if (exp_rdy[c]) gid[c] = '0;
  endtask

  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) step(3'b000, name);
  endtask

  // ---------------- return monitor ----------------
  logic [W-1:0] mon_e;
  logic         mon_got;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int c = 0; c < 3; c++) begin
        if (vld[c]) begin
          mon_got = 1'b0;
          case (c)
            0: if (exp_q0.size() > 0) begin mon_e = exp_q0.pop_front(); mon_got = 1'b1; end
            1: if (exp_q1.size() > 0) begin mon_e = exp_q1.pop_front(); mon_got = 1'b1; end
            default: if (exp_q2.size() > 0) begin mon_e = exp_q2.pop_front(); mon_got = 1'b1; end
          endcase
          if (!mon_got) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid client %0d @cycle %0d: got valid=1 expected valid=0", c, cyc);
          end else begin
            chk($sformatf("ret_cycle_c%0d", c), D'(cyc), D'(mon_e[W-1:D]));
            chk($sformatf("ret_data_c%0d", c), dat[c], mon_e[D-1:0]);
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int c = 0; c < 3; c++) begin
      gid[c] = '0; ben[c] = '0; addr[c] = '0; m_addr[c] = '0;
    end
    m_ben = '0;

    // Reset with a pending request: ready must stay low, outputs zero
    gid[0] = 3'b001; ben[0] = 4'hF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",     D'(rdy), '0);
    chk("rst_bank_en",   D'(read_bank_en_o), '0);
    chk("rst_addr",      D'(read_addr_o), '0);
    chk("rst_valid",     D'(vld), '0);
    chk("rst_conv_data", conv_read_data_o, '0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    gid[0] = '0;
    idle(1, "post_rst");

    // 1: single conv read from group 1
    gid[0] = 3'b010; ben[0] = 4'hF; addr[0] = {4{12'h123}};
    step(3'b001, "t1_acc");
    idle(5, "t1_wait");

    // 2: all three clients contend for group 0
    gid[0] = 3'b001; ben[0] = 4'hF;    addr[0] = {12'h00A, 12'h00B, 12'h00C, 12'h00D};
    gid[1] = 3'b001; ben[1] = 4'b0011; addr[1] = {12'h1A0, 12'h1B0, 12'h1C0, 12'h1D0};
    gid[2] = 3'b001; ben[2] = 4'b1100; addr[2] = {12'hFFF, 12'h800, 12'h001, 12'h7FE};
    step(3'b001, "t2_conv");
    step(3'b010, "t2_misc");
    step(3'b100, "t2_save");
    idle(5, "t2_wait");

    // 3: parallel groups
    gid[0] = 3'b001; ben[0] = 4'hF; addr[0] = {12'h111, 12'h222, 12'h333, 12'h444};
    gid[1] = 3'b010; ben[1] = 4'hF; addr[1] = {12'h555, 12'h666, 12'h777, 12'h888};
    gid[2] = 3'b100; ben[2] = 4'hF; addr[2] = {12'h999, 12'hAAA, 12'hBBB, 12'hCCC};
    step(3'b111, "t3_par");
    idle(5, "t3_wait");

    // 4: bank mask on group 2
    gid[1] = 3'b100; ben[1] = 4'b0101; addr[1] = {12'h0F1, 12'h0F2, 12'h0F3, 12'h0F4};
    step(3'b010, "t4_mask");
    idle(5, "t4_wait");

    // 5: illegal multi-hot group id
    gid[2] = 3'b011; ben[2] = 4'hF; addr[2] = {4{12'h321}};
    step(3'b000, "t5_illegal");
    step(3'b000, "t5_illegal_hold");
    gid[2] = '0;
    idle(5, "t5_wait");

    // Zero bank enable: accepted, nothing issued, zero data returned
    gid[0] = 3'b010; ben[0] = 4'h0; addr[0] = {4{12'h456}};
    step(3'b001, "zero_en");
    idle(5, "zero_en_wait");

    // 6: reset while a conv read is in flight
    gid[0] = 3'b001; ben[0] = 4'hF; addr[0] = {4{12'hABC}};
    step(3'b001, "t6_acc");
    step(3'b000, "t6_issue");
    rst_n = 1'b0;
    exp_q0.delete();
    m_ben = '0;
    for (int c = 0; c < 3; c++) m_addr[c] = '0;
    gid[0] = 3'b001; ben[0] = 4'h3; addr[0] = {4{12'h010}};
    gid[1] = 3'b001; ben[1] = 4'hC; addr[1] = {4{12'h020}};
    @(negedge clk);
    chk("t6_rst_ready",   D'(rdy), '0);
    chk("t6_rst_bank_en", D'(read_bank_en_o), '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(3'b001, "t6_conv_first");
    step(3'b010, "t6_misc_next");
    idle(6, "t6_wait");

    // Every expected return must have been seen
    chk("drain_conv", D'(exp_q0.size()), '0);
    chk("drain_misc", D'(exp_q1.size()), '0);
    chk("drain_save", D'(exp_q2.size()), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
